// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with synchronous write and a read-data register that only
// updates when an access is performed.
module dmem_array #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              access,
  input  logic              write,
  input  logic              zero,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (access && write && !zero)
      mem[idx] <= wdata;
  end

  // Stores are write-through so the core sees the stored word with ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rdata <= '0;
    else if (access) begin
      if (zero)
        rdata <= '0;
      else if (write)
        rdata <= wdata;
      else
        rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory with LATENCY wait states and a stall output.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              ready,
  output logic              stall,
  output logic              misalign
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              req;
  logic              access;
  logic              mis_addr;
  logic [IDX_W-1:0]  idx;
  logic              unused_addr;

  assign req         = memRead | memWrite;
  assign idx         = addr[IDX_W+1:2];
  assign unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  assign mis_addr = |addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mis_q <= 1'b0;
    else if (access)
      mis_q <= mis_addr;
  end
`else
  assign mis_addr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // A request vanishing during WAIT is a protocol violation: abort without writing.
  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req)
          state_nxt = IDLE;
        else if (cnt == '0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state == IDLE && req)
      cnt <= LAT_LOAD;
    else if (state == WAIT && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  always_comb begin
    ready = (state == RESP);
    stall = req & ~ready;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ready & mis_q;
`else
    misalign = 1'b0;
`endif
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .access (access),
    .write  (memWrite),
    .zero   (mis_addr),
    .idx    (idx),
    .wdata  (writeData),
    .rdata  (readData)
  );

endmodule
